// File: rtl/code_event_queue_if.sv
// Handshake bundle between the key encoder/consumer and code_event_queue.
// Signal names follow the encoder-facing port list of the queue.
interface code_event_queue_if #(
    parameter int DEPTH = 4,
    parameter int W     = 3
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          EN;
    logic [W-1:0]  code_in;
    logic          code_valid;
    logic [W-1:0]  out_code;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output EN, code_in, code_valid, out_ready,
        input  out_code, out_valid, count, overflow
    );

    modport slave (
        input  EN, code_in, code_valid, out_ready,
        output out_code, out_valid, count, overflow
    );
endinterface

// File: rtl/code_event_queue.sv
// Edge-detecting event queue behind the 8-to-3 encoder: one entry per new code, show-ahead FIFO.
// Define CODE_EVENT_QUEUE_OVF_STICKY_EN for a sticky overflow flag; default is a one-cycle pulse.
module code_event_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    code_event_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          prev_valid_q, prev_valid_d;
    logic [W-1:0]  prev_code_q, prev_code_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [W-1:0]  mem [DEPTH];

    logic evt, full, empty, pop, push, drop;

    always_comb begin
        evt   = q.EN & q.code_valid & (~prev_valid_q | (q.code_in != prev_code_q));
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        pop   = ~empty & q.out_ready;
        // A full queue still accepts an event when the head leaves in the same cycle.
        push  = evt & (~full | pop);
        drop  = evt & full & ~pop;
    end

    always_comb begin
        prev_valid_d = 1'b0;
        prev_code_d  = prev_code_q;
        if (q.EN) begin
            prev_valid_d = q.code_valid;
            prev_code_d  = q.code_in;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

`ifdef CODE_EVENT_QUEUE_OVF_STICKY_EN
        overflow_d = overflow_q | drop;
`else
        overflow_d = drop;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid_q <= 1'b0;
            prev_code_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            prev_valid_q <= prev_valid_d;
            prev_code_q  <= prev_code_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= q.code_in;
        end
    end

    assign q.out_valid = ~empty;
    assign q.out_code  = empty ? '0 : mem[rd_ptr_q];
    assign q.count     = count_q;
    assign q.overflow  = overflow_q;
endmodule

// File: tb/tb_code_event_queue.sv
// Self-checking bench for code_event_queue: table of vectors with hand-derived
// occupancy/overflow, plus a code scoreboard checking order and head value.
module tb_code_event_queue;
    localparam int DEPTH = 4;
    localparam int W     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    code_event_queue_if #(.DEPTH(DEPTH), .W(W)) bus ();

    code_event_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    typedef struct {
        bit         rst;
        bit         en;
        bit         v;
        logic [2:0] code;
        bit         rdy;
        int         cnt;
        bit         ovp;
        bit         ovs;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         step_no  = 0;
    bit         m_prev_valid = 1'b0;
    logic [2:0] m_prev_code  = '0;

    function automatic void add(bit r, bit e, bit v, int c, bit rd, int cnt, bit ovp, bit ovs);
        vec_t x;
        x.rst = r; x.en = e; x.v = v; x.code = 3'(c); x.rdy = rd;
        x.cnt = cnt; x.ovp = ovp; x.ovs = ovs;
        vecs.push_back(x);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, step_no, act, exp);
        end
    endtask

    // One clock: drive at negedge, update the scoreboard, sample 1 ns after the rising edge.
    task automatic step(input vec_t x);
        bit         evt, pop;
        int         exp_code;
        logic [2:0] popped;
        @(negedge clk);
        rst            = x.rst;
        bus.EN         = x.en;
        bus.code_valid = x.v;
        bus.code_in    = x.code;
        bus.out_ready  = x.rdy;
        evt = x.en && x.v && (!m_prev_valid || x.code != m_prev_code);
        if (x.rst) begin
            sb.delete();
            m_prev_valid = 1'b0;
            m_prev_code  = '0;
        end else begin
            pop = (sb.size() != 0) && x.rdy;
            if (pop) begin
                popped = sb.pop_front();
                check("pop_code", int'(bus.out_code), int'(popped));
            end
            if (evt && (sb.size() < DEPTH)) sb.push_back(x.code);
            if (x.en) begin
                m_prev_valid = x.v;
                m_prev_code  = x.code;
            end else begin
                m_prev_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        step_no++;
        exp_code = (sb.size() != 0) ? int'(sb[0]) : 0;
        $display("step %0d rst=%0b en=%0b v=%0b code=%0d rdy=%0b -> count=%0d out_valid=%0b out_code=%0d overflow=%0b",
                 step_no, x.rst, x.en, x.v, x.code, x.rdy, bus.count, bus.out_valid, bus.out_code, bus.overflow);
        check("count", int'(bus.count), x.cnt);
        check("out_valid", int'(bus.out_valid), int'(x.cnt != 0));
        check("head_code", int'(bus.out_code), exp_code);
        check("sb_depth", int'(bus.count), sb.size());
`ifdef CODE_EVENT_QUEUE_OVF_STICKY_EN
        check("overflow", int'(bus.overflow), int'(x.ovs));
`else
        check("overflow", int'(bus.overflow), int'(x.ovp));
`endif
    endtask

    task automatic s(bit r, bit e, bit v, int c, bit rd, int cnt, bit ovp, bit ovs);
        vec_t x;
        x.rst = r; x.en = e; x.v = v; x.code = 3'(c); x.rdy = rd;
        x.cnt = cnt; x.ovp = ovp; x.ovs = ovs;
        step(x);
    endtask

    initial begin
        bus.EN = 1'b0; bus.code_valid = 1'b0; bus.code_in = '0; bus.out_ready = 1'b0;

        // Reset state
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // Held code 5 yields one entry, then drain
        for (int i = 0; i < 6; i++) add(0, 1, 1, 5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        // Stepping codes with consumer ready: occupancy stays at 1
        for (int c = 0; c < 8; c++) add(0, 1, 1, c, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        // Fill, drop code 6, then full + pop accepts code 7, drain
        for (int c = 1; c <= 4; c++) add(0, 1, 1, c, 0, c, 0, 0);
        add(0, 1, 1, 6, 0, 4, 1, 1);
        add(0, 1, 1, 6, 0, 4, 0, 1);
        add(0, 1, 1, 7, 1, 4, 0, 1);
        for (int i = 3; i >= 0; i--) add(0, 0, 0, 0, 1, i, 0, 1);
        // Back-to-back drops keep the pulse high
        for (int c = 1; c <= 4; c++) add(0, 1, 1, c, 0, c, 0, 1);
        add(0, 1, 1, 5, 0, 4, 1, 1);
        add(0, 1, 1, 6, 0, 4, 1, 1);
        add(0, 0, 0, 0, 0, 4, 0, 1);
        for (int i = 3; i >= 0; i--) add(0, 0, 0, 0, 1, i, 0, 1);
        // EN toggle with code 3 held; EN=0 blocks capture
        add(0, 1, 1, 3, 0, 1, 0, 1);
        add(0, 0, 1, 3, 0, 1, 0, 1);
        add(0, 1, 1, 3, 0, 2, 0, 1);
        add(0, 0, 1, 3, 0, 2, 0, 1);
        add(0, 0, 1, 5, 0, 2, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 1);
        // Valid dropped and raised with the same code
        add(0, 1, 1, 2, 0, 1, 0, 1);
        add(0, 1, 0, 2, 0, 1, 0, 1);
        add(0, 1, 1, 2, 0, 2, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Mid-operation reset with an event present
        s(0, 1, 1, 1, 0, 1, 0, 1);
        s(0, 1, 1, 2, 0, 2, 0, 1);
        s(0, 1, 1, 3, 0, 3, 0, 1);
        s(1, 1, 1, 4, 1, 0, 0, 0);
        s(0, 0, 0, 4, 0, 0, 0, 0);
        // Capture latency from empty after reset
        s(0, 1, 1, 4, 0, 1, 0, 0);
        s(0, 0, 0, 0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
